// File: rtl/dbg_reg_pkg.sv
`default_nettype none
// ============================================================================
// dbg_reg_pkg : shared types for the debug register access initiator
// Revision    : 1.0
// ============================================================================
package dbg_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HALT = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ      = 3'd3,
`ifdef DBG_REG_READBACK_EN
    ST_VERIFY    = 3'd4,
`endif
    ST_RESP      = 3'd5
  } type_dbg_reg_state_e;

  typedef enum logic [1:0] {
    ERR_OK                = 2'd0,
    ERR_HALT_TIMEOUT      = 2'd1,
    ERR_READBACK_MISMATCH = 2'd2
  } type_dbg_rsp_err_e;

  localparam int DEFAULT_HALT_TIMEOUT = 16;

endpackage
`default_nettype wire

// File: rtl/dbg_reg_access.sv
`default_nettype none
// ============================================================================
// dbg_reg_access : debug-side initiator for register file reads/writes,
//                  waits for core halt, one response per command.
// Optional       : DBG_REG_READBACK_EN adds a post-write verify cycle.
// Revision       : 1.0
// ============================================================================
module dbg_reg_access
  import dbg_reg_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int HALT_TIMEOUT = DEFAULT_HALT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [1:0]        rsp_err_o,
  input  logic              core_halted_i,
  output logic              dbg2rf_wr_req_o,
  output logic [ADDR_W-1:0] dbg2rf_addr_o,
  output logic [DATA_W-1:0] dbg2rf_wdata_o,
  input  logic [DATA_W-1:0] rf2dbg_rdata_i
);

  localparam logic [7:0] CNT_LAST = 8'(HALT_TIMEOUT - 1);

  type_dbg_reg_state_e state;
  logic                is_write;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [7:0]          cnt;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          err_q;
  logic                addr_zero;

  assign addr_zero       = (addr_q == '0);
  assign cmd_ready_o     = (state == ST_IDLE) && !rst;
  // x0 is hardwired, so a write to it never reaches the register file
  assign dbg2rf_wr_req_o = (state == ST_WRITE) && !addr_zero;
  assign dbg2rf_addr_o   = addr_q;
  assign dbg2rf_wdata_o  = wdata_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rdata_q;
  assign rsp_err_o       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      is_write    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            is_write <= cmd_write_i;
            addr_q   <= cmd_addr_i;
            wdata_q  <= cmd_wdata_i;
            cnt      <= '0;
            state    <= ST_WAIT_HALT;
          end
        end
        ST_WAIT_HALT: begin
          if (core_halted_i) begin
            state <= is_write ? ST_WRITE : ST_READ;
          end else if (cnt == CNT_LAST) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= '0;
            err_q       <= ERR_HALT_TIMEOUT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_WRITE: begin
          rdata_q <= '0;
          err_q   <= ERR_OK;
`ifdef DBG_REG_READBACK_EN
          state   <= ST_VERIFY;
`else
          state       <= ST_RESP;
          rsp_valid_q <= 1'b1;
`endif
        end
        ST_READ: begin
          rdata_q     <= addr_zero ? '0 : rf2dbg_rdata_i;
          err_q       <= ERR_OK;
          state       <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
`ifdef DBG_REG_READBACK_EN
        ST_VERIFY: begin
          // the register file wrote on the previous negedge, so data is visible now
          err_q       <= (!addr_zero && (rf2dbg_rdata_i != wdata_q)) ?
                         ERR_READBACK_MISMATCH : ERR_OK;
          state       <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
`endif
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/dbg_reg_access.md
Name: dbg_reg_access

Overview:
- Debug-side initiator for the register file's debug write port and debug read path.
- Accepts single register access commands (read/write) from the debug transport over a valid/ready handshake.
- Requires the core to be halted before touching the register file, then drives the access and returns one response per command.
- Sits between the debug module command decoder and the register file.

Parameters:
ADDR_W, 5, register address width (32 architectural registers)
DATA_W, 32, register data width (XLEN)
HALT_TIMEOUT, 16, max cycles spent in WAIT_HALT before an error response; legal range 1..255

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command ready; 1 only in IDLE
cmd_write_i  input  1  1 = write, 0 = read
cmd_addr_i  input  ADDR_W  register address
cmd_wdata_i  input  DATA_W  write data
rsp_valid_o  output  1  response valid; held until accepted
rsp_ready_i  input  1  response ready
rsp_rdata_o  output  DATA_W  read data; 0 for writes and errors
rsp_err_o  output  2  0 OK, 1 HALT_TIMEOUT, 2 READBACK_MISMATCH
core_halted_i  input  1  core is halted
dbg2rf_wr_req_o  output  1  register file debug write request
dbg2rf_addr_o  output  ADDR_W  debug write/read address
dbg2rf_wdata_o  output  DATA_W  debug write data
rf2dbg_rdata_i  input  DATA_W  asynchronous read data for dbg2rf_addr_o

Behaviour:
- Clocking and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: state IDLE; cmd_ready_o=1 once rst deasserts; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; dbg2rf_wr_req_o=0; dbg2rf_addr_o=0; dbg2rf_wdata_o=0; timeout counter 0. While rst=1, cmd_ready_o=0.
- States: IDLE, WAIT_HALT, WRITE, READ, (VERIFY), RESP.
- IDLE: on cmd_valid_i & cmd_ready_o at posedge N, latch write/addr/wdata into registers driving dbg2rf_addr_o/dbg2rf_wdata_o, clear counter, go to WAIT_HALT.
- WAIT_HALT:
  - If core_halted_i=1, go to WRITE (write) or READ (read).
  - Else increment counter; when counter reaches HALT_TIMEOUT-1 with no halt, go to RESP with err=1, rdata=0.
- WRITE: dbg2rf_wr_req_o=1 for exactly this one cycle (decoded from state), so the register file's negedge write captures it. Address 0 is suppressed: wr_req stays 0 and err=0. Go to RESP (or VERIFY when the feature is enabled).
- READ: sample rf2dbg_rdata_i at the end of the cycle into rsp_rdata_o. Address 0 returns 0 regardless of input. Go to RESP.
- RESP: rsp_valid_o=1; rdata and err stable until rsp_valid_o & rsp_ready_i, then go to IDLE. The next command can be accepted in the cycle after the handshake.
- Latency (halted at N+1): WRITE or READ at N+2; rsp_valid_o first high at N+3. Throughput is one command per 4 cycles minimum.
- core_halted_i dropping after WAIT_HALT is ignored; the operation completes.
- Command inputs are ignored outside IDLE.
- Reset mid-operation: the state returns to IDLE at the reset edge and no response is issued. A write already in its WRITE cycle is not retracted.

Optional Feature:
- Macro DBG_REG_READBACK_EN.
- Enabled: WRITE goes to VERIFY. VERIFY compares rf2dbg_rdata_i with the latched wdata; a mismatch gives err=2. Address 0 skips the compare, giving err=0. Write latency becomes N+4.
- Disabled: the VERIFY state and comparator are absent; err=2 is never produced.

Decomposition:
- Package dbg_reg_pkg: state enum type_dbg_reg_state_e, response error enum type_dbg_rsp_err_e (OK/HALT_TIMEOUT/READBACK_MISMATCH), and the default HALT_TIMEOUT constant.
- No sub-module; the counter and FSM are inline.

Test Plan:
- Halted, write addr 5 data 0xDEADBEEF -> dbg2rf_wr_req_o high exactly one cycle at N+2 with addr 5/data 0xDEADBEEF; response at N+3, err=0, rdata=0.
- Halted, read addr 5 with rf2dbg_rdata_i=0x12345678 -> rsp_valid_o at N+3, rdata=0x12345678, err=0.
- Never halted, HALT_TIMEOUT=4, read addr 3 -> no wr_req, err=1, rdata=0; cmd_ready_o low throughout.
- Write addr 0 data 0xFFFFFFFF -> wr_req never asserted, err=0; read addr 0 with input 0xAAAA5555 -> rdata=0.
- rsp_ready_i held low 10 cycles -> rsp_valid_o, rdata, err stable; cmd_valid_i ignored; next command accepted the cycle after the handshake.
- DBG_REG_READBACK_EN with the bench returning 0x0 after a write of 0x1 -> err=2; matching value -> err=0 at N+4; rst asserted in WAIT_HALT -> IDLE next cycle, no response.
